// File: rtl/paridade_arbitro.sv
// Round-robin arbiter sharing one 9-bit parity checker among N_REQ requesters,
// with a one-entry output register and a saturating error counter.
module paridade_arbitro #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 8,
  parameter int ODD   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [9*N_REQ-1:0] req_dado,
  output logic [N_REQ-1:0]   req_ready,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [2:0]         resp_id,
  output logic [7:0]         resp_dado,
  output logic               resp_erro,
  output logic [CNT_W-1:0]   err_count,
  input  logic               clr_cnt
);

  logic [2:0] ptr;
  logic [2:0] sel;
  logic       found;
  logic       free;
  logic       accept;
  logic       perr;
  logic [8:0] word;
  int         idx;

  // Search ptr, ptr+1, ... wrapping; first pending requester wins.
  always_comb begin
    found = 1'b0;
    sel   = ptr;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        sel   = 3'(idx);
      end
    end
  end

  assign free      = !resp_valid || resp_ready;
  assign accept    = free && found && !rst;
  assign req_ready = accept ? (N_REQ'(1) << sel) : '0;
  assign word      = req_dado[9*int'(sel) +: 9];
  assign perr      = (^word) ^ (ODD != 0);

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_dado  <= '0;
      resp_erro  <= 1'b0;
      ptr        <= '0;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_id    <= sel;
      resp_dado  <= word[7:0];
      resp_erro  <= perr;
      ptr        <= (sel == 3'(N_REQ-1)) ? 3'd0 : sel + 3'd1;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

  // Clear has priority over a simultaneous increment.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt)
      err_count <= '0;
    else if (accept && perr && (err_count != {CNT_W{1'b1}}))
      err_count <= err_count + 1'b1;
  end

endmodule

// File: tb/tb_paridade_arbitro.sv
// Scoreboard bench: two instances (even/8-bit counter, odd/2-bit counter) driven
// by shared random and directed requester traffic, checked against a queue model.
module tb_paridade_arbitro;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [9*N-1:0]  req_dado;
  logic            resp_ready;
  logic            clr_cnt;
  logic [N-1:0]    rdy0, rdy1;
  logic            rv0, rv1, re0, re1;
  logic [2:0]      rid0, rid1;
  logic [7:0]      rd0, rd1;
  logic [7:0]      cnt0;
  logic [1:0]      cnt1;

  always #5 clk = ~clk;

  paridade_arbitro #(.N_REQ(N), .CNT_W(8), .ODD(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_dado(req_dado),
    .req_ready(rdy0), .resp_valid(rv0), .resp_ready(resp_ready),
    .resp_id(rid0), .resp_dado(rd0), .resp_erro(re0),
    .err_count(cnt0), .clr_cnt(clr_cnt));

  paridade_arbitro #(.N_REQ(N), .CNT_W(2), .ODD(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_dado(req_dado),
    .req_ready(rdy1), .resp_valid(rv1), .resp_ready(resp_ready),
    .resp_id(rid1), .resp_dado(rd1), .resp_erro(re1),
    .err_count(cnt1), .clr_cnt(clr_cnt));

  typedef struct {
    int         id;
    logic [7:0] d;
    logic       e;
  } exp_t;

  exp_t q[$];
  int   nchk = 0;
  int   nerr = 0;

  // Stimulus-side state: pending words per requester and the reference model.
  logic       pend [N];
  logic [8:0] dado [N];
  logic       t_rst, t_rdy, t_clr;
  int         m_ptr;
  logic       m_valid;
  int         m_cnt0, m_cnt1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    int   g;
    logic e;
    @(negedge clk);
    #2;
    rst        = t_rst;
    resp_ready = t_rdy;
    clr_cnt    = t_clr;
    for (int i = 0; i < N; i++) begin
      req_valid[i]         = pend[i];
      req_dado[9*i +: 9]   = dado[i];
    end
    #1;
    g = -1;
    if (!t_rst && (!m_valid || t_rdy))
      for (int k = 0; k < N; k++)
        if (g < 0 && pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    chk("req_ready0", 32'(rdy0), (g >= 0) ? (32'd1 << g) : 32'd0);
    chk("req_ready1", 32'(rdy1), (g >= 0) ? (32'd1 << g) : 32'd0);
    chk("resp_valid", 32'(rv0), 32'(m_valid));
    chk("resp_valid1", 32'(rv1), 32'(m_valid));
    chk("err_count0", 32'(cnt0), 32'(m_cnt0));
    chk("err_count1", 32'(cnt1), 32'(m_cnt1));
    if (t_rst) begin
      m_valid = 1'b0; m_ptr = 0; m_cnt0 = 0; m_cnt1 = 0;
      q.delete();
    end else begin
      e = ^dado[(g >= 0) ? g : 0];
      if (t_clr) begin
        m_cnt0 = 0; m_cnt1 = 0;
      end else if (g >= 0) begin
        if (e && m_cnt0 < 255) m_cnt0++;
        if (!e && m_cnt1 < 3) m_cnt1++;
      end
      if (g >= 0) begin
        q.push_back('{id: g, d: dado[g][7:0], e: e});
        m_valid = 1'b1;
        m_ptr   = (g + 1) % N;
        pend[g] = 1'b0;
      end else if (t_rdy) begin
        m_valid = 1'b0;
      end
    end
  endtask

  // Monitor: pops on every output handshake; also checks hold under backpressure.
  initial begin
    exp_t x;
    logic       held = 1'b0;
    logic [2:0] h_id;
    logic [7:0] h_d;
    logic       h_e;
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held) begin
          chk("hold_id", 32'(rid0), 32'(h_id));
          chk("hold_dado", 32'(rd0), 32'(h_d));
          chk("hold_erro", 32'(re0), 32'(h_e));
        end
        held = rv0 && !resp_ready;
        h_id = rid0; h_d = rd0; h_e = re0;
        if (rv0 && resp_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_resp", 32'(rv0), 32'd0);
          end else begin
            x = q.pop_front();
            chk("resp_id0", 32'(rid0), 32'(x.id));
            chk("resp_dado0", 32'(rd0), 32'(x.d));
            chk("resp_erro0", 32'(re0), 32'(x.e));
            chk("resp_id1", 32'(rid1), 32'(x.id));
            chk("resp_dado1", 32'(rd1), 32'(x.d));
            chk("resp_erro1", 32'(re1), 32'(!x.e));
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    t_rdy = 1'b1; t_clr = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    rst = 1'b1; resp_ready = 1'b0; clr_cnt = 1'b0; req_valid = '0; req_dado = '0;
    m_ptr = 0; m_valid = 1'b0; m_cnt0 = 0; m_cnt1 = 0;
    t_rst = 1'b1; t_rdy = 1'b1; t_clr = 1'b0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b1;
      dado[i] = 9'($urandom_range(0, 511));
    end

    // Reset with all requesters valid.
    step();
    step();
    chk("rst_resp_id", 32'(rid0), 32'd0);
    chk("rst_resp_dado", 32'(rd0), 32'd0);
    chk("rst_resp_erro", 32'(re0), 32'd0);
    t_rst = 1'b0;

    // Continuous requests: grants must rotate 0,1,2,3,...
    for (int k = 0; k < 10; k++) begin
      step();
      for (int i = 0; i < N; i++)
        if (!pend[i]) begin
          pend[i] = 1'b1;
          dado[i] = 9'($urandom_range(0, 511));
        end
    end
    idle(3);

    // Single good word from requester 2, then an error word from requester 1.
    pend[2] = 1'b1; dado[2] = 9'h101; step();
    idle(2);
    pend[1] = 1'b1; dado[1] = 9'h007; step();
    idle(2);

    // Backpressure for 5 cycles with all requesters pending.
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b1;
      dado[i] = 9'($urandom_range(0, 511));
    end
    t_rdy = 1'b0;
    for (int k = 0; k < 5; k++) step();
    t_rdy = 1'b1;
    for (int k = 0; k < 4; k++) step();
    idle(3);

    // Saturation of the 2-bit counter (9'h003 is an error only for odd parity).
    for (int k = 0; k < 5; k++) begin
      pend[0] = 1'b1; dado[0] = 9'h003; step();
    end
    pend[0] = 1'b1; dado[0] = 9'h003; t_clr = 1'b1; step();
    t_clr = 1'b0;
    idle(2);

    // Random traffic with occasional clear and reset.
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1;
          dado[i] = 9'($urandom_range(0, 511));
        end
      t_rdy = ($urandom_range(0, 3) != 0);
      t_clr = ($urandom_range(0, 39) == 0);
      t_rst = ($urandom_range(0, 149) == 0);
      step();
    end
    t_rst = 1'b0;
    idle(6);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
